// File: rtl/ccg_lut_bank_seq_if.sv
// Config, vector-in, result-out and sweep-control signals of the LUT bank.
interface ccg_lut_bank_seq_if #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 15,
  parameter int OIDX_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [OIDX_W-1:0]      cfg_addr;
  logic [(1<<NUM_IN)-1:0] cfg_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_IN-1:0]      in_x;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_OUT-1:0]     out_f;
  logic [NUM_IN-1:0]      out_x;
  logic                   out_last;
  logic                   sweep_start;
  logic                   sweep_busy;
  logic                   sweep_done;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, in_valid, in_x, out_ready, sweep_start,
    input  cfg_ready, in_ready, out_valid, out_f, out_x, out_last, sweep_busy, sweep_done
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, in_valid, in_x, out_ready, sweep_start,
    output cfg_ready, in_ready, out_valid, out_f, out_x, out_last, sweep_busy, sweep_done
  );
endinterface

// File: rtl/ccg_lut_bank_seq.sv
// Programmable multi-output truth-table bank with exhaustive sweep mode; 2-cycle latency.
// Backpressure: out_ready low freezes both stages; in_ready and cfg_ready drop accordingly.
module ccg_lut_bank_seq #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 15,
  parameter int OIDX_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input logic               clk,
  input logic               rst,
  ccg_lut_bank_seq_if.slave bus
);
  localparam int TT_W = 1 << NUM_IN;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  typedef struct packed {
    logic [NUM_IN-1:0] x;
    logic              last;
  } s1_t;

  typedef struct packed {
    logic [NUM_OUT-1:0] f;
    logic [NUM_IN-1:0]  x;
    logic               last;
  } s2_t;

  state_t             state, state_nxt;
  logic [NUM_IN-1:0]  cnt;
  logic [TT_W-1:0]    tt [NUM_OUT];
  logic               s1_vld, s2_vld;
  s1_t                s1_dat, inj_dat;
  s2_t                s2_dat;
  logic [NUM_OUT-1:0] lut_f;
  logic               stall, pipe_empty, inj_vld, cnt_max, cfg_we;

  assign stall      = s2_vld && !bus.out_ready;
  assign pipe_empty = !s1_vld && !s2_vld;
  assign cnt_max    = (cnt == {NUM_IN{1'b1}});
  assign cfg_we     = bus.cfg_valid && bus.cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.sweep_start)     state_nxt = SWEEP;
      SWEEP:   if (!stall && cnt_max)   state_nxt = DRAIN;
      DRAIN:   if (pipe_empty)          state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // sweep_start wins over in_valid in IDLE; sweep vectors come from cnt.
  always_comb begin
    bus.cfg_ready  = 1'b0;
    bus.in_ready   = 1'b0;
    bus.sweep_done = 1'b0;
    inj_vld        = 1'b0;
    inj_dat        = '{x: bus.in_x, last: 1'b0};
    case (state)
      IDLE: begin
        bus.cfg_ready = pipe_empty;
        bus.in_ready  = !stall && !bus.sweep_start;
        inj_vld       = bus.in_valid && !stall && !bus.sweep_start;
      end
      SWEEP: begin
        inj_vld = !stall;
        inj_dat = '{x: cnt, last: cnt_max};
      end
      DRAIN:   bus.sweep_done = pipe_empty;
      default: ;
    endcase
  end

  assign bus.sweep_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst)                                 cnt <= '0;
    else if (state == IDLE && bus.sweep_start) cnt <= '0;
    else if (state == SWEEP && !stall)       cnt <= cnt + 1'b1;
  end

  // Out-of-range addresses match no entry and are silently dropped.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_OUT; j++) begin
      if (rst)
        tt[j] <= '0;
      else if (cfg_we && bus.cfg_addr == OIDX_W'(j))
        tt[j] <= bus.cfg_data;
    end
  end

  always_comb begin
    lut_f = '0;
    for (int j = 0; j < NUM_OUT; j++) lut_f[j] = tt[j][s1_dat.x];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_dat <= '0;
      s2_dat <= '0;
    end else if (!stall) begin
      s1_vld <= inj_vld;
      s2_vld <= s1_vld;
      if (inj_vld) s1_dat <= inj_dat;
      if (s1_vld)  s2_dat <= '{f: lut_f, x: s1_dat.x, last: s1_dat.last};
    end
  end

  assign bus.out_valid = s2_vld;
  assign bus.out_f     = s2_dat.f;
  assign bus.out_x     = s2_dat.x;
  assign bus.out_last  = s2_dat.last;
endmodule

// File: tb/tb_ccg_lut_bank_seq.sv
// Directed bench for ccg_lut_bank_seq: vector table plus hand-written sweep/stall/reset sequences.
module tb_ccg_lut_bank_seq;
  localparam int NUM_IN = 4, NUM_OUT = 15, OIDX_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ccg_lut_bank_seq_if #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .OIDX_W(OIDX_W)) bus ();
  ccg_lut_bank_seq #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .OIDX_W(OIDX_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  x;
    logic [14:0] f;
  } vec_t;
  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_data  = d;
    #1;
    chk("cfg_ready_idle", bus.cfg_ready, 1'b1);
    step();
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] t0;
    logic [15:0] pat;
    logic [19:0] snap;
    logic [3:0]  rdy_pat;
    logic        stalled, done_seen, found;
    int          nout, nlast, ndone, hs, c;

    t0 = 16'h3333;
    rdy_pat = 4'b1001;
    // tt0 = ~x1, tt1 = ~x0|~x3, tt2 = (x==0)|(x==15), tt14 = x2
    vecs[0] = '{x: 4'd9,  f: 15'h0001};
    vecs[1] = '{x: 4'd4,  f: 15'h4003};
    vecs[2] = '{x: 4'd0,  f: 15'h0007};
    vecs[3] = '{x: 4'd15, f: 15'h4004};
    vecs[4] = '{x: 4'd6,  f: 15'h4002};
    vecs[5] = '{x: 4'd11, f: 15'h0000};
    vecs[6] = '{x: 4'd13, f: 15'h4001};

    rst = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.in_valid = 1'b0;  bus.in_x = '0;
    bus.out_ready = 1'b1; bus.sweep_start = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rst_cfg_ready", bus.cfg_ready, 1'b1);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_f", bus.out_f, 15'h0);
    chk("rst_out_x", bus.out_x, 4'h0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_busy", bus.sweep_busy, 1'b0);
    chk("rst_done", bus.sweep_done, 1'b0);

    // Single vector through unprogrammed tables
    bus.in_valid = 1'b1; bus.in_x = 4'b1010;
    step();
    bus.in_valid = 1'b0;
    chk("lat_s1_only", bus.out_valid, 1'b0);
    step();
    chk("lat_valid", bus.out_valid, 1'b1);
    chk("lat_f", bus.out_f, 15'h0);
    chk("lat_x", bus.out_x, 4'b1010);
    chk("lat_last", bus.out_last, 1'b0);
    step();
    chk("lat_consumed", bus.out_valid, 1'b0);

    cfg_write(4'd0, 16'h3333);
    cfg_write(4'd1, 16'h55FF);
    cfg_write(4'd2, 16'h8001);
    cfg_write(4'd14, 16'hF0F0);
    cfg_write(4'd15, 16'hFFFF);

    // Back-to-back table vectors, one result per cycle
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin
        bus.in_valid = 1'b1;
        bus.in_x = vecs[i].x;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        chk("vec_valid", bus.out_valid, 1'b1);
        chk("vec_f", bus.out_f, vecs[i-1].f);
        chk("vec_x", bus.out_x, vecs[i-1].x);
        chk("vec_last", bus.out_last, 1'b0);
      end
    end
    bus.in_valid = 1'b0;
    step();

    // Config refused while the pipeline holds a vector
    bus.in_valid = 1'b1; bus.in_x = 4'd1;
    step();
    bus.in_valid = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_data = 16'h0000;
    #1;
    chk("cfg_rdy_s1", bus.cfg_ready, 1'b0);
    step();
    chk("cfg_rdy_s2", bus.cfg_ready, 1'b0);
    chk("cfg_blk_f0", bus.out_f[0], 1'b1);
    bus.cfg_valid = 1'b0;
    step();

    // Sweep with out_ready held high
    bus.sweep_start = 1'b1;
    #1;
    chk("sw_start_in_ready", bus.in_ready, 1'b0);
    step();
    bus.sweep_start = 1'b0;
    pat = '0; nout = 0; nlast = 0; ndone = 0;
    for (int cc = 1; cc <= 20; cc++) begin
      step();
      if (cc <= 18) begin
        chk("sw_in_ready", bus.in_ready, 1'b0);
        chk("sw_busy", bus.sweep_busy, 1'b1);
      end
      chk("sw_valid", bus.out_valid, (cc >= 2 && cc <= 17));
      if (bus.out_valid) begin
        chk("sw_x", bus.out_x, nout[3:0]);
        chk("sw_last", bus.out_last, (nout == 15));
        pat[bus.out_x] = bus.out_f[0];
        if (bus.out_last) nlast++;
        nout++;
      end
      if (bus.sweep_done) begin
        ndone++;
        chk("sw_done_cycle", cc, 18);
      end
      if (cc == 19) begin
        chk("sw_idle_busy", bus.sweep_busy, 1'b0);
        chk("sw_idle_in_ready", bus.in_ready, 1'b1);
      end
    end
    chk("sw_count", nout, 16);
    chk("sw_pattern", pat, 16'h3333);
    chk("sw_nlast", nlast, 1);
    chk("sw_ndone", ndone, 1);

    // Sweep with out_ready 1,0,0,1 and ignored config/sweep_start pokes
    bus.sweep_start = 1'b1;
    step();
    bus.sweep_start = 1'b0;
    hs = 0; c = 0; done_seen = 1'b0;
    while (c < 150 && !done_seen) begin
      bus.out_ready = rdy_pat[c % 4];
      if (hs >= 2 && hs < 10) begin
        bus.sweep_start = 1'b1;
        bus.cfg_valid = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_data = 16'h0000;
      end else begin
        bus.sweep_start = 1'b0;
        bus.cfg_valid = 1'b0;
      end
      #1;
      if (bus.cfg_valid) chk("tg_cfg_ready", bus.cfg_ready, 1'b0);
      if (bus.sweep_done) begin
        done_seen = 1'b1;
        chk("tg_done_after_16", hs, 16);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("tg_x", bus.out_x, hs[3:0]);
        chk("tg_f0", bus.out_f[0], t0[hs]);
        chk("tg_last", bus.out_last, (hs == 15));
        hs++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      snap = {bus.out_f, bus.out_x, bus.out_last};
      step();
      c++;
      if (stalled) chk("tg_stall_hold", {bus.out_valid, bus.out_f, bus.out_x, bus.out_last}, {1'b1, snap});
    end
    bus.sweep_start = 1'b0; bus.cfg_valid = 1'b0; bus.out_ready = 1'b1;
    chk("tg_done_seen", done_seen, 1'b1);
    chk("tg_handshakes", hs, 16);
    chk("tg_idle_after", bus.sweep_busy, 1'b0);

    // Reset in the middle of a sweep
    bus.sweep_start = 1'b1;
    step();
    bus.sweep_start = 1'b0;
    found = 1'b0;
    for (int cc = 0; cc < 40 && !found; cc++) begin
      step();
      if (bus.out_valid && bus.out_x == 4'd7) found = 1'b1;
    end
    chk("mr_reached_7", found, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_out_valid", bus.out_valid, 1'b0);
    chk("mr_busy", bus.sweep_busy, 1'b0);
    chk("mr_out_f", bus.out_f, 15'h0);
    chk("mr_cfg_ready", bus.cfg_ready, 1'b1);
    ndone = 0;
    bus.in_valid = 1'b1; bus.in_x = 4'd0;
    step();
    if (bus.sweep_done) ndone++;
    bus.in_valid = 1'b0;
    step();
    chk("mr_tbl_valid", bus.out_valid, 1'b1);
    chk("mr_tbl_zero", bus.out_f, 15'h0);
    for (int cc = 0; cc < 25; cc++) begin
      if (bus.sweep_done) ndone++;
      step();
    end
    chk("mr_no_done", ndone, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
